ovm_txn_mux_fifo: RTL
=====================

Name: ovm_txn_mux_fifo

Overview:
- Parametrised N-channel transaction buffer-and-merge block used by the RTL harness side of the OVM environment. It succeeds the single-stream transaction FIFO.
- Each input channel feeds its own circular FIFO. A round-robin arbiter merges the channels onto one valid/ready output stream and tags each beat with its source channel.
- A mode parameter selects the channel semantics:
  - blocking: backpressure on full;
  - analysis: never blocks, drops on full and counts every drop.

Parameters:
- N_CH, 4, number of input channels (1..16).
- DATA_W, 32, transaction payload width in bits.
- DEPTH, 8, entries per channel FIFO. Must be a power of 2 and at least 2.
- DROP_ON_FULL, 0, mode select. 0 = blocking (backpressure). 1 = analysis (never block, drop on full).
- CNT_W, 16, width of each per-channel drop counter.

Ports:
- sig_clock  in  1  single clock; all state updates on its rising edge.
- sig_reset  in  1  synchronous reset, active-high.
- in_valid  in  N_CH  per-channel write request.
- in_ready  out  N_CH  per-channel write acceptance.
- in_data  in  N_CH*DATA_W  payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  merged output has a beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  head entry of the granted channel.
- out_ch  out  max(1,clog2(N_CH))  index of the granted channel.
- level  out  N_CH*(clog2(DEPTH)+1)  per-channel occupancy, 0..DEPTH.
- drop_cnt  out  N_CH*CNT_W  per-channel count of dropped writes. Always 0 when DROP_ON_FULL=0.
- clr_drop  in  1  synchronous clear of all drop counters.

Behaviour:
- Clocking and reset:
  - One clock, sig_clock. Reset sig_reset is synchronous and active-high; it takes effect on a clock edge and has priority over all other inputs.
  - While sig_reset is high, all FIFOs are emptied and rd/wr pointers are set to 0.
  - Reset values: level=0, drop_cnt=0, out_valid=0, out_ch=0, out_data=0, grant lock cleared.
  - The round-robin pointer resets to N_CH-1, so channel 0 has first priority.
  - in_ready is forced to 0 while sig_reset=1.
  - Reset asserted mid-transfer discards all stored entries. No beat is presented in the cycle after reset.
- Write side, per channel i:
  - A write occurs when in_valid[i] && in_ready[i] at the edge. The entry is stored at wr_ptr, wr_ptr increments, and level increments.
  - DROP_ON_FULL=0: in_ready[i] = !full[i]. There is no pass-through when full, even if the same channel pops in that cycle.
  - DROP_ON_FULL=1: in_ready[i] = 1 outside reset.
    - A write to a full channel that is not popped in the same cycle is dropped: data is discarded and drop_cnt[i] increments, saturating at 2^CNT_W-1.
    - A write to a full channel that is popped in the same cycle is stored (level stays DEPTH).
  - clr_drop=1: all drop counters load 0. If a drop on channel i happens in the same cycle, drop_cnt[i] loads 1.
- Read side and arbitration:
  - out_valid = 1 whenever any FIFO is non-empty. Write-to-output latency is 1 cycle; there is no same-cycle bypass from in_data to out_data.
  - Grant selection: the first non-empty channel searching upward from rr_ptr+1, modulo N_CH.
  - out_data and out_ch reflect the granted channel's head entry.
  - Pop occurs when out_valid && out_ready. The granted FIFO's rd_ptr increments, level decrements, and rr_ptr loads the granted index.
  - Stability: if out_valid=1 and out_ready=0, the grant is locked. out_ch and out_data must stay unchanged until the pop, even if a higher-priority channel becomes non-empty.
  - When out_valid=0, out_ch and out_data hold their last values.
- Simultaneous push and pop on the same non-full channel: level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- One pop per cycle maximum. Aggregate throughput is 1 beat/cycle.

Test Plan:
- Reset then single write: ch2 writes 0xA5A5_0001 at cycle 0 with out_ready=1. Expect out_valid=1, out_ch=2, out_data=0xA5A5_0001 at cycle 1. level[2] reads 1, then 0 after the pop.
- Round-robin: all 4 channels hold 2 entries each, out_ready=1 constant. Expect out_ch sequence 0,1,2,3,0,1,2,3, then out_valid=0. Every level reaches 0.
- Stall stability: ch3 is non-empty and granted with out_ready=0 for 5 cycles while ch0 is written. Expect out_ch=3 and out_data unchanged for all 5 cycles. On the out_ready=1 edge, ch3 pops; the next grant is ch0.
- Blocking full (DROP_ON_FULL=0): write 9 beats to ch1 with out_ready=0. Expect in_ready[1]=0 after 8 accepted beats and level[1]=8. drop_cnt stays 0; the 9th beat is accepted only after one pop.
- Analysis drop (DROP_ON_FULL=1, CNT_W=2): write 13 beats to ch0 with out_ready=0. Expect level[0]=8 and drop_cnt[0] saturating at 3.
  - Then pulse clr_drop together with a 14th write. Expect drop_cnt[0]=1.
  - Next, full push and pop in the same cycle. Expect the entry stored, no drop, level[0]=8.
- Reset mid-operation: channels hold 3,1,0,5 entries; assert sig_reset for 1 cycle. Expect all level=0, out_valid=0, drop_cnt=0. The first post-reset grant goes to the lowest non-empty channel.

Source files
------------

// File: rtl/ovm_txn_mux_fifo.sv
// N-channel transaction buffer: one circular FIFO per channel merged onto a single
// valid/ready stream by a round-robin arbiter. It either backpressures or drops on full.
module ovm_txn_mux_fifo #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W        = 16,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic                     sig_clock,
  input  logic                     sig_reset,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [N_CH*LVL_W-1:0]    level,
  output logic [N_CH*CNT_W-1:0]    drop_cnt,
  input  logic                     clr_drop
);

  logic [DATA_W-1:0] mem [N_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [N_CH];
  logic [PTR_W-1:0]  rd_ptr [N_CH];
  logic [LVL_W-1:0]  lvl    [N_CH];
  logic [CNT_W-1:0]  cnt    [N_CH];

  logic [CH_W-1:0]   rr_ptr, lock_ch, hold_ch, gnt, gnt_search, idx;
  logic              lock_vld, found, pop;
  logic [DATA_W-1:0] hold_data;
  logic [N_CH-1:0]   nonempty, full, pop_ch, wr_en, drop;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      nonempty[i]                  = (lvl[i] != '0);
      full[i]                      = (lvl[i] == LVL_W'(DEPTH));
      level[i*LVL_W +: LVL_W]      = lvl[i];
      drop_cnt[i*CNT_W +: CNT_W]   = cnt[i];
    end
  end

  // First non-empty channel searching upward from rr_ptr+1, wrapping at N_CH.
  always_comb begin
    gnt_search = rr_ptr;
    found      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CH_W'((int'(rr_ptr) + k) % N_CH);
      if (!found && nonempty[idx]) begin
        gnt_search = idx;
        found      = 1'b1;
      end
    end
  end

  // A stalled beat keeps its channel even if a higher-priority channel fills meanwhile.
  assign gnt       = lock_vld ? lock_ch : gnt_search;
  assign out_valid = |nonempty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_ch   = hold_ch;
    out_data = hold_data;
    if (out_valid) begin
      out_ch   = gnt;
      out_data = mem[gnt][rd_ptr[gnt]];
    end
  end

  // A full channel only accepts data in analysis mode, and only if it is popped that cycle.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      pop_ch[i]   = pop && (gnt == CH_W'(i));
      in_ready[i] = !sig_reset && ((DROP_ON_FULL != 0) || !full[i]);
      wr_en[i]    = in_valid[i] && in_ready[i] && (!full[i] || pop_ch[i]);
      drop[i]     = in_valid[i] && in_ready[i] && full[i] && !pop_ch[i];
    end
  end

  always_ff @(posedge sig_clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        lvl[i]    <= '0;
        cnt[i]    <= '0;
      end
      rr_ptr    <= CH_W'(N_CH - 1);
      lock_vld  <= 1'b0;
      lock_ch   <= '0;
      hold_ch   <= '0;
      hold_data <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_en[i])  wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_ch[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        lvl[i] <= lvl[i] + LVL_W'(wr_en[i]) - LVL_W'(pop_ch[i]);
        if (clr_drop)
          cnt[i] <= drop[i] ? CNT_W'(1) : '0;
        else if (drop[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
      if (pop) rr_ptr <= gnt;
      lock_vld <= out_valid && !out_ready;
      lock_ch  <= gnt;
      if (out_valid) begin
        hold_ch   <= gnt;
        hold_data <= out_data;
      end
    end
  end

endmodule
